// File: rtl/vector_exec_pkg.sv
// vector_exec_pkg: shared constants and types for the execute-stage vector unit
package vector_exec_pkg;
    localparam int LANES  = 4;
    localparam int LANE_W = 32;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_SRA = 4'd7,
        OP_MUL = 4'd8,
        OP_MIN = 4'd9,
        OP_MAX = 4'd10
    } alu_op_e;

    // Codes 0-3 broadcast the lane of the same number
    localparam logic [2:0] RR_ROT_R = 3'd4;
    localparam logic [2:0] RR_ROT_L = 3'd5;
    localparam logic [2:0] RR_REV   = 3'd6;
    localparam logic [2:0] RR_PASS  = 3'd7;

    typedef enum logic {IDLE, MUL} state_e;
endpackage

// File: rtl/vector_lane_alu.sv
// vector_lane_alu: combinational single-lane ALU; unlisted codes pass operand a
module vector_lane_alu
    import vector_exec_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] y
);
    logic [4:0] sh;

    assign sh = b[4:0];

    always_comb begin
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << sh;
            OP_SRL:  y = a >> sh;
            OP_SRA:  y = $signed(a) >>> sh;
            OP_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  y = ($signed(a) < $signed(b)) ? b : a;
            default: y = a;
        endcase
    end
endmodule

// File: rtl/execute_vector_unit.sv
// execute_vector_unit: 4-lane execute stage with operand rerouting and a
// shared multiplier that walks one lane per cycle while stalling ID/EX.
module execute_vector_unit
    import vector_exec_pkg::*;
(
    input  logic                    clock,
    input  logic                    async_reset,
    input  logic                    sync_reset,
    input  logic                    vector_op_E,
    input  logic [3:0]              ALU_op_E,
    input  logic                    select_operand_1_vector_E,
    input  logic                    rerouting_select_E,
    input  logic [2:0]              rerouting_code_E,
    input  logic [5:0]              rd_E,
    input  logic [LANES*LANE_W-1:0] vector_reg_data_0_E,
    input  logic [LANES*LANE_W-1:0] vector_reg_data_1_E,
    input  logic [LANE_W-1:0]       scalar_reg_data_1_E,
    output logic [LANES*LANE_W-1:0] result_vector_M,
    output logic                    result_valid_M,
    output logic [5:0]              rd_M,
    output logic                    stall_E
);
    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

    vec_t        op0, rr, op1, alu_res, mul_a, mul_b, acc, mul_res;
    state_e      state, state_n;
    logic [1:0]  cnt;
    logic [5:0]  rd_hold;
    logic [LANE_W-1:0] prod;
    logic        is_mul, last;

    assign op0    = vector_reg_data_0_E;
    assign op1    = select_operand_1_vector_E ? vector_reg_data_1_E : {LANES{scalar_reg_data_1_E}};
    assign is_mul = ALU_op_E == OP_MUL;
    assign last   = cnt == 2'd3;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int RR = (i + 1) % LANES;
        localparam int RL = (i + LANES - 1) % LANES;
        localparam int RV = LANES - 1 - i;
        assign rr[i] = (!rerouting_select_E || rerouting_code_E == RR_PASS) ? op0[i] :
                       !rerouting_code_E[2]         ? op0[rerouting_code_E[1:0]] :
                       rerouting_code_E == RR_ROT_R ? op0[RR] :
                       rerouting_code_E == RR_ROT_L ? op0[RL] :
                       rerouting_code_E == RR_REV   ? op0[RV] : op0[i];
        vector_lane_alu u_alu (
            .op (ALU_op_E),
            .a  (rr[i]),
            .b  (op1[i]),
            .y  (alu_res[i])
        );
    end

    // Single shared multiplier; the lane in flight overwrites its slot of the accumulator
    assign prod = mul_a[cnt] * mul_b[cnt];

    always_comb begin
        mul_res      = acc;
        mul_res[cnt] = prod;
    end

    always_comb begin
        state_n = state;
        stall_E = 1'b0;
        state_n = (state == IDLE) ? ((vector_op_E && is_mul) ? MUL : IDLE) : (last ? IDLE : MUL);
        stall_E = (state == IDLE) ? (vector_op_E && is_mul) : !last;
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            state           <= IDLE;
            cnt             <= '0;
            mul_a           <= '0;
            mul_b           <= '0;
            acc             <= '0;
            rd_hold         <= '0;
            result_vector_M <= '0;
            result_valid_M  <= 1'b0;
            rd_M            <= '0;
        end else if (!sync_reset) begin
            state           <= IDLE;
            cnt             <= '0;
            mul_a           <= '0;
            mul_b           <= '0;
            acc             <= '0;
            rd_hold         <= '0;
            result_vector_M <= '0;
            result_valid_M  <= 1'b0;
            rd_M            <= '0;
        end else begin
            state          <= state_n;
            result_valid_M <= 1'b0;
            if (state == IDLE && vector_op_E) begin
                if (is_mul) begin
                    mul_a   <= rr;
                    mul_b   <= op1;
                    rd_hold <= rd_E;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    result_vector_M <= alu_res;
                    rd_M            <= rd_E;
                    result_valid_M  <= 1'b1;
                end
            end else if (state == MUL) begin
                acc <= mul_res;
                cnt <= cnt + 2'd1;
                if (last) begin
                    result_vector_M <= mul_res;
                    rd_M            <= rd_hold;
                    result_valid_M  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_execute_vector_unit.sv
// tb_execute_vector_unit: directed and randomized checks against a lane-array reference model
module tb_execute_vector_unit;
    logic         clock = 1'b0;
    logic         async_reset = 1'b0;
    logic         sync_reset = 1'b1;
    logic         vector_op_E = 1'b0;
    logic [3:0]   ALU_op_E = '0;
    logic         select_operand_1_vector_E = 1'b1;
    logic         rerouting_select_E = 1'b0;
    logic [2:0]   rerouting_code_E = '0;
    logic [5:0]   rd_E = '0;
    logic [127:0] vector_reg_data_0_E = '0;
    logic [127:0] vector_reg_data_1_E = '0;
    logic [31:0]  scalar_reg_data_1_E = '0;
    logic [127:0] result_vector_M;
    logic         result_valid_M;
    logic [5:0]   rd_M;
    logic         stall_E;

    int n_chk = 0;
    int n_pass = 0;
    logic [127:0] last_res = '0;
    logic [5:0]   last_rd = '0;

    execute_vector_unit dut (
        .clock                     (clock),
        .async_reset               (async_reset),
        .sync_reset                (sync_reset),
        .vector_op_E               (vector_op_E),
        .ALU_op_E                  (ALU_op_E),
        .select_operand_1_vector_E (select_operand_1_vector_E),
        .rerouting_select_E        (rerouting_select_E),
        .rerouting_code_E          (rerouting_code_E),
        .rd_E                      (rd_E),
        .vector_reg_data_0_E       (vector_reg_data_0_E),
        .vector_reg_data_1_E       (vector_reg_data_1_E),
        .scalar_reg_data_1_E       (scalar_reg_data_1_E),
        .result_vector_M           (result_vector_M),
        .result_valid_M            (result_valid_M),
        .rd_M                      (rd_M),
        .stall_E                   (stall_E)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Reference: pick source lane per rerouting rule, then apply the op to each lane pair
    function automatic logic [127:0] model(input int op, input bit sel1, input bit rsel, input int code,
                                           input logic [127:0] a, input logic [127:0] b, input logic [31:0] s);
        logic [31:0] src[4];
        logic [31:0] x, y;
        logic [127:0] r;
        int k;
        for (int i = 0; i < 4; i++) src[i] = a[i*32 +: 32];
        for (int i = 0; i < 4; i++) begin
            if (!rsel || code == 7) k = i;
            else if (code < 4) k = code;
            else if (code == 4) k = (i + 1) % 4;
            else if (code == 5) k = (i + 3) % 4;
            else k = 3 - i;
            x = src[k];
            y = sel1 ? b[i*32 +: 32] : s;
            case (op)
                0:  r[i*32 +: 32] = x + y;
                1:  r[i*32 +: 32] = x - y;
                2:  r[i*32 +: 32] = x & y;
                3:  r[i*32 +: 32] = x | y;
                4:  r[i*32 +: 32] = x ^ y;
                5:  r[i*32 +: 32] = x << y[4:0];
                6:  r[i*32 +: 32] = x >> y[4:0];
                7:  r[i*32 +: 32] = 32'(int'(x) >>> y[4:0]);
                8:  r[i*32 +: 32] = 32'(64'(x) * 64'(y));
                9:  r[i*32 +: 32] = (int'(x) < int'(y)) ? x : y;
                10: r[i*32 +: 32] = (int'(x) > int'(y)) ? x : y;
                default: r[i*32 +: 32] = x;
            endcase
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd_vec;
        logic [127:0] v;
        logic [31:0] edges[4] = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++)
            v[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
        return v;
    endfunction

    task automatic drive(input int op, input bit sel1, input bit rsel, input int code, input logic [5:0] rd,
                         input logic [127:0] a, input logic [127:0] b, input logic [31:0] s);
        vector_op_E               = 1'b1;
        ALU_op_E                  = 4'(op);
        select_operand_1_vector_E = sel1;
        rerouting_select_E        = rsel;
        rerouting_code_E          = 3'(code);
        rd_E                      = rd;
        vector_reg_data_0_E       = a;
        vector_reg_data_1_E       = b;
        scalar_reg_data_1_E       = s;
    endtask

    task automatic do_single(input string tag, input int op, input bit sel1, input bit rsel, input int code,
                             input logic [5:0] rd, input logic [127:0] a, input logic [127:0] b,
                             input logic [31:0] s, input logic [127:0] exp);
        drive(op, sel1, rsel, code, rd, a, b, s);
        #2 check({tag, "_stall"}, 128'(stall_E), 128'd0);
        step;
        check({tag, "_valid"}, 128'(result_valid_M), 128'd1);
        check({tag, "_res"}, result_vector_M, exp);
        check({tag, "_rd"}, 128'(rd_M), 128'(rd));
        last_res = exp;
        last_rd  = rd;
    endtask

    task automatic do_mul(input string tag, input bit sel1, input bit rsel, input int code, input logic [5:0] rd,
                          input logic [127:0] a, input logic [127:0] b, input logic [31:0] s,
                          input logic [127:0] exp);
        int n = 0;
        drive(8, sel1, rsel, code, rd, a, b, s);
        #2;
        while (stall_E && n < 8) begin
            n++;
            step;
            check({tag, "_busy_valid"}, 128'(result_valid_M), 128'd0);
            #2;
        end
        check({tag, "_stall_cycles"}, 128'(n), 128'd4);
        step;
        check({tag, "_valid"}, 128'(result_valid_M), 128'd1);
        check({tag, "_res"}, result_vector_M, exp);
        check({tag, "_rd"}, 128'(rd_M), 128'(rd));
        last_res = exp;
        last_rd  = rd;
    endtask

    task automatic do_idle;
        vector_op_E = 1'b0;
        ALU_op_E    = 4'($urandom);
        #2 check("idle_stall", 128'(stall_E), 128'd0);
        step;
        check("idle_valid", 128'(result_valid_M), 128'd0);
        check("idle_hold_res", result_vector_M, last_res);
        check("idle_hold_rd", 128'(rd_M), 128'(last_rd));
    endtask

    task automatic rand_op;
        logic [127:0] a = rnd_vec();
        logic [127:0] b = rnd_vec();
        logic [31:0]  s = $urandom;
        bit sel1 = 1'($urandom);
        bit rsel = 1'($urandom);
        int code = $urandom_range(0, 7);
        logic [5:0] rd = 6'($urandom);
        int r = $urandom_range(0, 11);
        int op = $urandom_range(0, 14);
        if (op >= 8) op++;
        if (r == 0) do_idle;
        else if (r == 1) do_mul("rmul", sel1, rsel, code, rd, a, b, s, model(8, sel1, rsel, code, a, b, s));
        else do_single("rop", op, sel1, rsel, code, rd, a, b, s, model(op, sel1, rsel, code, a, b, s));
    endtask

    initial begin
        logic [127:0] abcd = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
        #12;
        check("rst_res", result_vector_M, 128'd0);
        check("rst_valid", 128'(result_valid_M), 128'd0);
        check("rst_rd", 128'(rd_M), 128'd0);
        check("rst_stall", 128'(stall_E), 128'd0);
        async_reset = 1'b1;
        step;

        do_single("add", 0, 1, 0, 0, 6'd3, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
                  32'd0, {32'd44, 32'd33, 32'd22, 32'd11});
        do_idle;
        do_single("sub", 1, 0, 0, 0, 6'd4, {32'h80000000, 32'd6, 32'd5, 32'd0}, rnd_vec(), 32'd5,
                  {32'h7FFFFFFB, 32'd1, 32'd0, 32'hFFFFFFFB});
        do_single("rev", 11, 1, 1, 6, 6'd5, abcd, rnd_vec(), 32'd0,
                  {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004});
        do_single("bcast2", 11, 1, 1, 2, 6'd6, abcd, rnd_vec(), 32'd0, {4{32'hCCCC0003}});
        do_single("rotr", 0, 0, 1, 4, 6'd7, abcd, rnd_vec(), 32'd0,
                  {32'hAAAA0001, 32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002});
        do_mul("mul", 1, 0, 0, 6'd9, {32'h10000, 32'hFFFFFFFF, 32'd3, 32'd2}, {32'h10000, 32'd2, 32'd9, 32'd7},
               32'd0, {32'd0, 32'hFFFFFFFE, 32'd27, 32'd14});
        do_single("add_after_mul", 0, 0, 0, 0, 6'd10, {32'd1, 32'd2, 32'd3, 32'd4}, rnd_vec(), 32'd100,
                  {32'd101, 32'd102, 32'd103, 32'd104});

        drive(8, 1, 0, 0, 6'd11, rnd_vec(), rnd_vec(), 32'd0);
        step;
        step;
        sync_reset  = 1'b0;
        vector_op_E = 1'b0;
        step;
        sync_reset = 1'b1;
        #2 check("flush_stall", 128'(stall_E), 128'd0);
        check("flush_valid", 128'(result_valid_M), 128'd0);
        check("flush_res", result_vector_M, 128'd0);
        check("flush_rd", 128'(rd_M), 128'd0);
        for (int i = 0; i < 3; i++) begin
            step;
            check("flush_no_pulse", 128'(result_valid_M), 128'd0);
        end
        last_res = '0;
        last_rd  = '0;
        do_single("add_after_flush", 0, 1, 0, 0, 6'd12, {4{32'd7}}, {4{32'd8}}, 32'd0, {4{32'd15}});

        drive(0, 1, 0, 0, 6'd13, {4{32'd1}}, {4{32'd1}}, 32'd0);
        sync_reset = 1'b0;
        step;
        sync_reset = 1'b1;
        check("flush_prio_valid", 128'(result_valid_M), 128'd0);
        check("flush_prio_res", result_vector_M, 128'd0);
        last_res = '0;
        last_rd  = '0;

        do_single("pre_async", 3, 0, 0, 0, 6'd14, {4{32'hF0}}, rnd_vec(), 32'h0F, {4{32'hFF}});
        drive(8, 1, 0, 0, 6'd15, rnd_vec(), rnd_vec(), 32'd0);
        step;
        step;
        #3 async_reset = 1'b0;
        vector_op_E = 1'b0;
        #1 check("async_res", result_vector_M, 128'd0);
        check("async_valid", 128'(result_valid_M), 128'd0);
        check("async_rd", 128'(rd_M), 128'd0);
        check("async_stall", 128'(stall_E), 128'd0);
        step;
        #2 async_reset = 1'b1;
        step;
        last_res = '0;
        last_rd  = '0;
        do_single("sra", 7, 1, 0, 0, 6'd16, {4{32'h80000000}}, {4{32'd31}}, 32'd0, {4{32'hFFFFFFFF}});

        for (int t = 0; t < 300; t++) rand_op;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/execute_vector_unit.md
# execute_vector_unit

Execute-stage vector datapath for the RV32I+vector pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its E-stage control and data outputs. It performs 4-lane × 32-bit operations, with optional lane rerouting of operand 0 and scalar broadcast of operand 1. Single-cycle ops produce a registered result for the EX/MEM boundary; vector multiply iterates one lane per cycle and stalls the upstream register.

## Interface
- LANES, 4, number of 32-bit lanes (fixed at 4; 128-bit vectors)
- LANE_W, 32, lane width in bits
- clock  in  1  single clock, rising edge
- async_reset  in  1  asynchronous, active-low; clears all state
- sync_reset  in  1  synchronous, active-low flush; aborts any op in flight
- vector_op_E  in  1  E-stage slot holds a valid vector instruction
- ALU_op_E  in  4  operation select (see Operation)
- select_operand_1_vector_E  in  1  1: operand 1 = vector_reg_data_1_E; 0: broadcast scalar_reg_data_1_E
- rerouting_select_E  in  1  apply rerouting to operand 0
- rerouting_code_E  in  3  lane permutation code
- rd_E  in  6  destination register
- vector_reg_data_0_E  in  128  operand 0 (lane 0 = bits [31:0])
- vector_reg_data_1_E  in  128  operand 1 when vector
- scalar_reg_data_1_E  in  32  scalar operand 1
- result_vector_M  out  128  registered result
- result_valid_M  out  1  one-cycle pulse, result_vector_M/rd_M valid
- rd_M  out  6  destination register of the result
- stall_E  out  1  combinational; upstream must hold ID/EX (deassert enabler) while high

## Operation
- Operand 0 rerouting (when rerouting_select_E=1) uses rerouting_code_E:
  - 0–3: broadcast lane k to all lanes.
  - 4: rotate right one lane (lane i ← lane i+1 mod 4).
  - 5: rotate left one lane.
  - 6: reverse lane order.
  - 7: pass-through.
- ALU_op_E, applied per lane:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is operand-1 lane bits [4:0].
  - 8 MUL: low 32 bits of the product, multi-cycle.
  - 9 MIN signed, 10 MAX signed.
  - 11–15: pass rerouted operand 0.
- Add/sub/mul wrap modulo 2^32 per lane; there is no carry between lanes.
- FSM states:
  - IDLE: accepts a new op when vector_op_E=1.
    - Non-MUL: compute and register the result, stay in IDLE.
    - MUL: capture the rerouted/broadcast operands and rd_E into internal registers, set lane counter to 0, go to MUL.
  - MUL: one shared 32×32 multiplier processes lane[counter] each cycle and writes its product into the accumulating result register.
    - Counter increments each cycle.
    - At counter=3: register the final result, pulse result_valid_M, return to IDLE.
    - E-stage inputs are ignored in this state.
- stall_E = (IDLE & vector_op_E & ALU_op_E==8) | (MUL & counter≠3).
- vector_op_E=0 in IDLE: result_valid_M=0; result_vector_M and rd_M hold their previous values.

## Timing
- Reset values, for both async_reset=0 and sync_reset=0 at a clock edge:
  - result_vector_M=0, result_valid_M=0, rd_M=0.
  - State IDLE, counter=0, so stall_E=0.
- Single-cycle op accepted in cycle N: result_valid_M=1 in N+1. Back-to-back issue is allowed every cycle.
- MUL accepted in cycle N:
  - stall_E=1 in cycles N through N+3 and 0 in N+4.
  - The held instruction is still present in E during N+4 and is ignored.
  - result_valid_M=1 in N+5.
  - The next E-stage op is accepted in N+5.
- sync_reset low during MUL: abort, state IDLE next cycle, no result_valid_M pulse, stall_E low that cycle.
- sync_reset has priority over a simultaneous op acceptance.
- async_reset mid-operation: immediate return to reset values, independent of clock.

## Structure
- Shared package vector_exec_pkg:
  - LANES and LANE_W constants.
  - ALU op enum (codes 0–10).
  - Rerouting code constants.
  - FSM state typedef {IDLE, MUL}.
- Sub-module vector_lane_alu: combinational single-lane ALU for ops 0–7, 9, 10, instantiated LANES times.
- The rerouting mux, broadcast mux, shared multiplier, FSM and output registers live in the top module.

## Test plan
- ADD, op0=lanes{1,2,3,4}, op1=lanes{10,20,30,40} → result {11,22,33,44} one cycle later, result_valid_M one pulse, stall_E never high.
- SUB with select_operand_1_vector_E=0, scalar=5, op0={0,5,6,0x80000000} → {0xFFFFFFFB,0,1,0x7FFFFFFB}.
- Rerouting code 6 with op0={A,B,C,D} and op 11 → {D,C,B,A}; code 2 → {C,C,C,C}.
- MUL, op0={2,3,0xFFFFFFFF,0x10000}, op1={7,9,2,0x10000}:
  - stall_E high for exactly 4 cycles.
  - Result {14,27,0xFFFFFFFE,0} with result_valid_M at N+5.
  - Single-cycle ADD issued in N+5 gives a valid result in N+6.
- sync_reset=0 at N+2 of a MUL → stall_E low in N+3, no result_valid_M pulse; a following ADD completes normally.
- async_reset asserted mid-MUL between clock edges → outputs zero and stall_E low immediately; SRA of 0x80000000 by 31 after release → 0xFFFFFFFF.
